// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle ARM-subset datapath: sequences fetch, decode,
// memory, execute and writeback steps and drives the datapath mux selects and strobes.
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic       Done,
    output logic       Illegal,
    output logic [3:0] o_dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_cmd;
    logic       w_irwrite, w_nextpc, w_regw, w_memw, w_pcs, w_done, w_illegal;
    logic [1:0] w_flagw;

    assign w_cmd       = Funct[4:1];
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // MemReady handshake: the FSM holds its memory request (FETCH, MEMRD, MEMWR)
    // stable every cycle MemReady is 0; the access completes in the cycle it is 1.
    always_comb begin
        w_next     = S_FETCH;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        w_flagw    = 2'b00;
        w_irwrite  = 1'b0;
        w_nextpc   = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_pcs      = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = MemReady;
                w_nextpc  = MemReady;
                w_next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
                w_done    = 1'b1;
                w_pcs     = (Rd == 4'hF);
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
                w_done = MemReady;
                w_next = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
                w_next  = S_ALUWB;
                case (w_cmd)
                    4'b0100: ALUControl = 2'b00;
                    4'b0010: ALUControl = 2'b01;
                    4'b0000: ALUControl = 2'b10;
                    4'b1100: ALUControl = 2'b11;
                    default: w_illegal  = 1'b1;
                endcase
                // Only arithmetic ops (add/sub) update carry/overflow.
                w_flagw = {Funct[0], Funct[0] & ((w_cmd == 4'b0100) | (w_cmd == 4'b0010))};
            end
            S_ALUWB: begin
                w_regw = 1'b1;
                w_done = 1'b1;
                w_pcs  = (Rd == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcs     = 1'b1;
                w_done    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are forced low combinationally while reset is held.
    assign IRWrite = reset & w_irwrite;
    assign NextPC  = reset & w_nextpc;
    assign RegW    = reset & w_regw;
    assign MemW    = reset & w_memw;
    assign PCS     = reset & w_pcs;
    assign Done    = reset & w_done;
    assign Illegal = reset & w_illegal;
    assign FlagW   = reset ? w_flagw : 2'b00;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed instructions plus random
// instruction streams compared cycle-by-cycle against a per-instruction output script.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, PCS, Done, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [3:0] dbg_state;
  logic [17:0] dut_vec;

  logic [17:0] exp_q[$];
  logic        mr_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .RegW(RegW), .MemW(MemW), .PCS(PCS), .Done(Done), .Illegal(Illegal),
    .o_dbg_state(dbg_state)
  );

  assign dut_vec = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                    FlagW, RegW, MemW, PCS, Done, Illegal};

  function automatic logic [17:0] mk(input logic irw, input logic npc, input logic adr,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] r, input logic [1:0] alu,
                                     input logic [1:0] flg, input logic regw,
                                     input logic memw, input logic pcs, input logic done,
                                     input logic ill);
    return {irw, npc, adr, a, b, r, alu, flg, regw, memw, pcs, done, ill};
  endfunction

  function automatic logic rnd_bit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic check(input string t, input logic [17:0] e);
    checks++;
    assert (dut_vec === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", t, dut_vec, e);
    end
  endtask

  task automatic push(input logic mr, input logic [17:0] v, input string t);
    mr_q.push_back(mr);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  // Expected per-cycle outputs of one whole instruction, with fw fetch stalls and
  // mw memory stalls; MemReady is a don't-care (randomised) outside memory waits.
  task automatic build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input int fw, input int mw);
    logic [3:0] cmd;
    logic       wb_pc;
    logic [1:0] alu;
    logic [1:0] flg;
    logic       ill;
    cmd   = f[4:1];
    wb_pc = (rd == 4'hF);
    for (int k = 0; k < fw; k++)
      push(1'b0, mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_wait");
    push(1'b1, mk(1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
    push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, op == 2'b11), "decode");
    if (op == 2'b10) begin
      push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "branch");
    end else if (op == 2'b01) begin
      push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "memadr");
      if (f[0]) begin
        for (int k = 0; k < mw; k++)
          push(1'b0, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "memrd_wait");
        push(1'b1, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "memrd");
        push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, wb_pc, 1'b1, 1'b0), "memwb");
      end else begin
        for (int k = 0; k < mw; k++)
          push(1'b0, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "memwr_wait");
        push(1'b1, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "memwr");
      end
    end else if (op == 2'b00) begin
      ill = 1'b0;
      alu = 2'b00;
      if (cmd == 4'b0100)      alu = 2'b00;
      else if (cmd == 4'b0010) alu = 2'b01;
      else if (cmd == 4'b0000) alu = 2'b10;
      else if (cmd == 4'b1100) alu = 2'b11;
      else                     ill = 1'b1;
      flg = {f[0], f[0] && (cmd == 4'b0100 || cmd == 4'b0010)};
      push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00, alu, flg, 1'b0, 1'b0, 1'b0, 1'b0, ill), "execute");
      push(rnd_bit(), mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, wb_pc, 1'b1, 1'b0), "aluwb");
    end
  endtask

  task automatic step();
    logic [17:0] e;
    string       t;
    MemReady = mr_q.pop_front();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    @(negedge clk);
    check(t, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input int fw, input int mw);
    Op = op;
    Funct = f;
    Rd = rd;
    build(op, f, rd, fw, mw);
    while (exp_q.size() > 0) step();
  endtask

  initial begin
    reset = 1'b0;
    MemReady = 1'b1;
    Op = 2'b00;
    Funct = 6'b0;
    Rd = 4'b0;
    #12;
    check("reset_outputs", mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    checks++;
    assert (dbg_state === 4'd0) else begin
      failures++;
      $error("FAIL reset_state got=%h exp=%h", dbg_state, 4'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b0;
    @(posedge clk);
    #1;

    run_instr(2'b00, 6'b001000, 4'd1, 0, 0);   // ADD immediate
    run_instr(2'b00, 6'b000101, 4'd2, 0, 0);   // SUBS register
    run_instr(2'b00, 6'b000001, 4'd3, 1, 0);   // ANDS
    run_instr(2'b00, 6'b011000, 4'hF, 0, 0);   // ORR to PC
    run_instr(2'b00, 6'b011110, 4'd4, 0, 0);   // undefined cmd
    run_instr(2'b01, 6'b000001, 4'hF, 0, 3);   // LDR to PC with stall
    run_instr(2'b01, 6'b000001, 4'd5, 0, 0);   // LDR no stall
    run_instr(2'b01, 6'b000000, 4'd6, 0, 2);   // STR with stall
    run_instr(2'b10, 6'b000000, 4'd0, 2, 0);   // branch
    run_instr(2'b11, 6'b111111, 4'hF, 0, 0);   // undefined op

    // Reset during a store stall, then release and resume fetching.
    Op = 2'b01;
    Funct = 6'b000000;
    Rd = 4'd7;
    build(2'b01, 6'b000000, 4'd7, 0, 6);
    for (int k = 0; k < 5; k++) step();
    exp_q.delete();
    mr_q.delete();
    tag_q.delete();
    MemReady = 1'b0;
    #1 reset = 1'b0;
    #1 check("rst_memwr_stall", mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    MemReady = 1'b1;
    #1 check("rst_memready_hi", mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_release_fetch", mk(1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    run_instr(2'b00, 6'b101001, 4'd8, 1, 0);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(op, f, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
